approx_adder_err_monitor: RTL and testbench

Parametrised, pipelined approximate adder with a built-in error monitor. It is the successor to the team's fixed 16-bit low-part-truncated adder netlists. It generalises operand width, lets the approximated low-part size and approximation mode be chosen per transaction, and computes the exact sum alongside the approximate one. Running error statistics are accumulated on-chip. It sits between an operand stimulus source and the error-evaluation capture logic, with valid/ready handshakes on both sides.

---
 rtl/approx_adder_pkg.sv | 27 ++
 rtl/approx_adder_err_monitor_if.sv | 28 ++
 rtl/approx_adder_core.sv | 50 +++++
 rtl/approx_adder_err_monitor.sv | 117 +++++++++++
 tb/tb_approx_adder_err_monitor.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/approx_adder_pkg.sv
// Shared types and helpers for the approximate adder with error monitor.
// Holds the per-beat approximation mode encoding and a width-generic saturating add.
package approx_adder_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_TRUNC = 2'd1,
        MODE_LOR   = 2'd2,
        MODE_CSPEC = 2'd3
    } mode_e;

    // Adds inc to acc and clamps the result to the largest w-bit value (w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int          w);
        logic [64:0] sum_s;
        logic [64:0] lim_s;
        sum_s = {1'b0, acc} + {1'b0, inc};
        lim_s = (65'd1 << w) - 65'd1;
        if (sum_s > lim_s) begin
            return lim_s[63:0];
        end else begin
            return sum_s[63:0];
        end
    endfunction

endpackage

// File: rtl/approx_adder_err_monitor_if.sv
// Operand-in / result-out valid-ready bus of the approximate adder.
// The master side is the stimulus/capture environment, the slave side is the adder.
interface approx_adder_err_monitor_if #(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [KW-1:0]    cfg_k;
    logic [1:0]       cfg_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum_apx;
    logic [WIDTH:0]   sum_ext;
    logic             err_flag;

    modport master (
        output in_valid, a, b, cfg_k, cfg_mode, out_ready,
        input  in_ready, out_valid, sum_apx, sum_ext, err_flag
    );

    modport slave (
        input  in_valid, a, b, cfg_k, cfg_mode, out_ready,
        output in_ready, out_valid, sum_apx, sum_ext, err_flag
    );
endinterface

// File: rtl/approx_adder_core.sv
// Combinational exact and approximate adder; the low k bits are approximated per mode.
// k is clamped to WIDTH, and k = 0 degenerates to the exact sum in every mode.
module approx_adder_core
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    input  mode_e            mode,
    output logic [WIDTH:0]   sum_apx,
    output logic [WIDTH:0]   sum_ext
);
    logic [KW-1:0]    k_s;
    logic [KW-1:0]    k_m1_s;
    logic [WIDTH:0]   lmask_w_s;
    logic [WIDTH-1:0] lmask_s;
    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH-1:0] b_sh_s;
    logic             cin_s;
    logic [WIDTH:0]   u_sum_s;
    logic [WIDTH:0]   u_spec_s;

    assign k_s       = (k > KW'(WIDTH)) ? KW'(WIDTH) : k;
    assign k_m1_s    = k_s - {{(KW-1){1'b0}}, 1'b1};
    assign lmask_w_s = ((WIDTH+1)'(1'b1) << k_s) - (WIDTH+1)'(1'b1);
    assign lmask_s   = lmask_w_s[WIDTH-1:0];
    assign a_sh_s    = a >> k_m1_s;
    assign b_sh_s    = b >> k_m1_s;
    // Speculated carry into the upper part comes from the top approximated bit pair only.
    assign cin_s     = (k_s != {KW{1'b0}}) & a_sh_s[0] & b_sh_s[0];
    assign u_sum_s   = {1'b0, a & ~lmask_s} + {1'b0, b & ~lmask_s};
    assign u_spec_s  = u_sum_s + ((WIDTH+1)'(cin_s) << k_s);
    assign sum_ext   = {1'b0, a} + {1'b0, b};

    // Select the approximate result for the requested mode.
    always_comb begin
        sum_apx = sum_ext;
        case (mode)
            MODE_EXACT: sum_apx = sum_ext;
            MODE_TRUNC: sum_apx = u_sum_s;
            MODE_LOR:   sum_apx = u_sum_s | {1'b0, (a | b) & lmask_s};
            MODE_CSPEC: sum_apx = u_spec_s;
            default:    sum_apx = sum_ext;
        endcase
    end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// Two-stage pipelined approximate adder with on-chip running error statistics.
// S1 captures the beat with its own cfg, S2 captures both sums; counters saturate.
module approx_adder_err_monitor
    import approx_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH + 1),
    parameter int CNT_W = 32,
    parameter int ACC_W = 40
) (
    input  logic                clk,
    input  logic                rst,
    approx_adder_err_monitor_if.slave bus,
    input  logic                stat_clr,
    output logic [CNT_W-1:0]    stat_n,
    output logic [CNT_W-1:0]    stat_nerr,
    output logic [ACC_W-1:0]    stat_abs,
    output logic [WIDTH:0]      stat_max
);
    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [KW-1:0]    s1_k_q, s1_k_d;
    mode_e            s1_mode_q, s1_mode_d;
    logic             s2_v_q, s2_v_d;
    logic [WIDTH:0]   s2_apx_q, s2_apx_d, s2_ext_q, s2_ext_d;
    logic             s2_err_q, s2_err_d;
    logic [CNT_W-1:0] n_q, n_d, nerr_q, nerr_d;
    logic [ACC_W-1:0] abs_q, abs_d;
    logic [WIDTH:0]   max_q, max_d;
    logic             s2_adv_s, s1_adv_s, xfer_s;
    logic [WIDTH:0]   core_apx_s, core_ext_s, e_s;

    assign s2_adv_s     = ~s2_v_q | bus.out_ready;
    assign s1_adv_s     = ~s1_v_q | s2_adv_s;
    assign xfer_s       = s2_v_q & bus.out_ready;
    assign e_s          = s2_ext_q - s2_apx_q;
    assign bus.in_ready = ~rst & s1_adv_s;
    assign bus.out_valid = s2_v_q;
    assign bus.sum_apx  = s2_apx_q;
    assign bus.sum_ext  = s2_ext_q;
    assign bus.err_flag = s2_err_q;
    assign stat_n       = n_q;
    assign stat_nerr    = nerr_q;
    assign stat_abs     = abs_q;
    assign stat_max     = max_q;

    approx_adder_core #(.WIDTH(WIDTH), .KW(KW)) u_core (
        .a       (s1_a_q),
        .b       (s1_b_q),
        .k       (s1_k_q),
        .mode    (s1_mode_q),
        .sum_apx (core_apx_s),
        .sum_ext (core_ext_s)
    );

    // Pipeline next state: each stage advances when the stage after it can take its content.
    always_comb begin
        s1_v_d = s1_v_q; s1_a_d = s1_a_q; s1_b_d = s1_b_q; s1_k_d = s1_k_q; s1_mode_d = s1_mode_q;
        s2_v_d = s2_v_q; s2_apx_d = s2_apx_q; s2_ext_d = s2_ext_q; s2_err_d = s2_err_q;
        if (s1_adv_s) begin
            s1_v_d    = bus.in_valid;
            s1_a_d    = bus.a;
            s1_b_d    = bus.b;
            s1_k_d    = bus.cfg_k;
            s1_mode_d = mode_e'(bus.cfg_mode);
        end else begin
            s1_v_d = s1_v_q;
        end
        if (s2_adv_s && s1_v_q) begin
            s2_v_d   = 1'b1;
            s2_apx_d = core_apx_s;
            s2_ext_d = core_ext_s;
            s2_err_d = (core_apx_s != core_ext_s);
        end else if (s2_adv_s) begin
            s2_v_d = 1'b0;
        end else begin
            s2_v_d = s2_v_q;
        end
    end

    // Statistics next state: a clear restarts from the concurrent transfer, if any.
    always_comb begin
        n_d = n_q; nerr_d = nerr_q; abs_d = abs_q; max_d = max_q;
        if (stat_clr) begin
            n_d    = xfer_s ? CNT_W'(1'b1) : {CNT_W{1'b0}};
            nerr_d = xfer_s ? CNT_W'(s2_err_q) : {CNT_W{1'b0}};
            abs_d  = xfer_s ? ACC_W'(sat_add(64'd0, 64'(e_s), ACC_W)) : {ACC_W{1'b0}};
            max_d  = xfer_s ? e_s : {(WIDTH+1){1'b0}};
        end else if (xfer_s) begin
            n_d    = CNT_W'(sat_add(64'(n_q), 64'd1, CNT_W));
            nerr_d = CNT_W'(sat_add(64'(nerr_q), 64'(s2_err_q), CNT_W));
            abs_d  = ACC_W'(sat_add(64'(abs_q), 64'(e_s), ACC_W));
            max_d  = (e_s > max_q) ? e_s : max_q;
        end else begin
            n_d = n_q;
        end
    end

    // State registers with synchronous reset; in-flight beats are dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0; s1_a_q <= {WIDTH{1'b0}}; s1_b_q <= {WIDTH{1'b0}};
            s1_k_q <= {KW{1'b0}}; s1_mode_q <= MODE_EXACT;
            s2_v_q <= 1'b0; s2_apx_q <= {(WIDTH+1){1'b0}}; s2_ext_q <= {(WIDTH+1){1'b0}};
            s2_err_q <= 1'b0;
            n_q <= {CNT_W{1'b0}}; nerr_q <= {CNT_W{1'b0}};
            abs_q <= {ACC_W{1'b0}}; max_q <= {(WIDTH+1){1'b0}};
        end else begin
            s1_v_q <= s1_v_d; s1_a_q <= s1_a_d; s1_b_q <= s1_b_d;
            s1_k_q <= s1_k_d; s1_mode_q <= s1_mode_d;
            s2_v_q <= s2_v_d; s2_apx_q <= s2_apx_d; s2_ext_q <= s2_ext_d;
            s2_err_q <= s2_err_d;
            n_q <= n_d; nerr_q <= nerr_d; abs_q <= abs_d; max_q <= max_d;
        end
    end

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed and randomised checks of approx_adder_err_monitor, including a CNT_W=4 build
// for counter saturation. Expected values are hand-computed or come from an independent model.
module tb_approx_adder_err_monitor;
    import approx_adder_pkg::*;

    typedef struct {
        logic [16:0] apx;
        logic [16:0] ext;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic stat_clr, stat_clr_s;
    logic [31:0] stat_n, stat_nerr;
    logic [39:0] stat_abs;
    logic [16:0] stat_max;
    logic [3:0]  sat_n, sat_nerr;
    logic [39:0] sat_abs;
    logic [16:0] sat_max;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    int del_cnt  = 0;
    int sat_acc  = 0;
    bit sb_en    = 1'b0;
    res_t exp_q[$];
    logic [63:0] m_n, m_nerr, m_abs, m_max;

    approx_adder_err_monitor_if #(.WIDTH(16)) bus ();
    approx_adder_err_monitor_if #(.WIDTH(16)) bus_s ();

    approx_adder_err_monitor #(.WIDTH(16), .CNT_W(32), .ACC_W(40)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stat_clr(stat_clr),
        .stat_n(stat_n), .stat_nerr(stat_nerr), .stat_abs(stat_abs), .stat_max(stat_max)
    );

    approx_adder_err_monitor #(.WIDTH(16), .CNT_W(4), .ACC_W(40)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s), .stat_clr(stat_clr_s),
        .stat_n(sat_n), .stat_nerr(sat_nerr), .stat_abs(sat_abs), .stat_max(sat_max)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [4:0] k, input logic [1:0] mode);
        int unsigned kk, ahi, bhi, cin, lo, ext, apx;
        res_t r;
        kk  = (k > 5'd16) ? 16 : int'(k);
        ext = 32'(a) + 32'(b);
        if (mode == 2'd0 || kk == 0) begin
            apx = ext;
        end else begin
            ahi = 32'(a) >> kk;
            bhi = 32'(b) >> kk;
            cin = (mode == 2'd3) ? (((32'(a) >> (kk - 1)) & (32'(b) >> (kk - 1))) & 32'd1) : 32'd0;
            lo  = (mode == 2'd2) ? ((32'(a) | 32'(b)) & ((32'd1 << kk) - 32'd1)) : 32'd0;
            apx = ((ahi + bhi + cin) << kk) | lo;
        end
        r.apx = apx[16:0];
        r.ext = ext[16:0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: note handshakes that will fire at the coming edge, then advance past it.
    task automatic step();
        res_t r;
        logic [16:0] e;
        #1;
        if (bus.in_valid && bus.in_ready) begin
            acc_cnt++;
            if (sb_en) exp_q.push_back(model(bus.a, bus.b, bus.cfg_k, bus.cfg_mode));
        end
        if (bus.out_valid && bus.out_ready) begin
            del_cnt++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 64'd1, 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("sb_sum_apx", 64'(bus.sum_apx), 64'(r.apx));
                    chk("sb_sum_ext", 64'(bus.sum_ext), 64'(r.ext));
                    chk("sb_err_flag", 64'(bus.err_flag), 64'(r.apx != r.ext));
                    e = r.ext - r.apx;
                    m_n++;
                    m_nerr += 64'(r.apx != r.ext);
                    m_abs += 64'(e);
                    if (64'(e) > m_max) m_max = 64'(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [4:0] k, input logic [1:0] mode,
                            input logic [16:0] e_apx, input logic [16:0] e_ext,
                            input logic [31:0] e_n, input logic [31:0] e_nerr,
                            input logic [39:0] e_abs, input logic [16:0] e_max);
        bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cfg_k = k; bus.cfg_mode = mode;
        step();
        bus.in_valid = 1'b0;
        step();
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "_sum_apx"}, 64'(bus.sum_apx), 64'(e_apx));
        chk({tag, "_sum_ext"}, 64'(bus.sum_ext), 64'(e_ext));
        chk({tag, "_err_flag"}, 64'(bus.err_flag), 64'(e_apx != e_ext));
        step();
        chk({tag, "_stat_n"}, 64'(stat_n), 64'(e_n));
        chk({tag, "_stat_nerr"}, 64'(stat_nerr), 64'(e_nerr));
        chk({tag, "_stat_abs"}, 64'(stat_abs), 64'(e_abs));
        chk({tag, "_stat_max"}, 64'(stat_max), 64'(e_max));
    endtask

    initial begin
        rst = 1'b1; stat_clr = 1'b0; stat_clr_s = 1'b0;
        bus.in_valid = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.cfg_k = 5'd0;
        bus.cfg_mode = 2'd0; bus.out_ready = 1'b1;
        bus_s.in_valid = 1'b0; bus_s.a = 16'h0; bus_s.b = 16'h0; bus_s.cfg_k = 5'd0;
        bus_s.cfg_mode = 2'd0; bus_s.out_ready = 1'b1;
        m_n = 64'd0; m_nerr = 64'd0; m_abs = 64'd0; m_max = 64'd0;
        step();
        step();
        chk("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum_apx", 64'(bus.sum_apx), 64'd0);
        chk("rst_stat_n", 64'(stat_n), 64'd0);
        chk("rst_stat_max", 64'(stat_max), 64'd0);

        // Saturation build: 20 erroring transfers into a 4-bit counter.
        bus_s.in_valid = 1'b1; bus_s.a = 16'h01FF; bus_s.b = 16'h0001;
        bus_s.cfg_k = 5'd9; bus_s.cfg_mode = 2'd1;
        for (int i = 0; i < 60 && sat_acc < 20; i++) begin
            #1;
            if (bus_s.in_valid && bus_s.in_ready) sat_acc++;
            @(posedge clk);
            #1;
            if (sat_acc >= 20) bus_s.in_valid = 1'b0;
        end
        step(); step(); step();
        chk("sat_accepted", 64'(sat_acc), 64'd20);
        chk("sat_stat_n", 64'(sat_n), 64'hF);
        chk("sat_stat_nerr", 64'(sat_nerr), 64'hF);
        chk("sat_stat_abs", 64'(sat_abs), 64'h2800);
        chk("sat_stat_max", 64'(sat_max), 64'h200);

        directed("exact",  16'hFFFF, 16'h0001, 5'd9,  2'd0, 17'h10000, 17'h10000, 1, 0, 40'h0,     17'h0);
        directed("trunc",  16'h01FF, 16'h0001, 5'd9,  2'd1, 17'h00000, 17'h00200, 2, 1, 40'h200,   17'h200);
        directed("lor",    16'h000F, 16'h0001, 5'd4,  2'd2, 17'h0000F, 17'h00010, 3, 2, 40'h201,   17'h200);
        directed("cspec1", 16'h0100, 16'h0100, 5'd9,  2'd3, 17'h00200, 17'h00200, 4, 2, 40'h201,   17'h200);
        directed("cspec2", 16'h0180, 16'h0080, 5'd9,  2'd3, 17'h00000, 17'h00200, 5, 3, 40'h401,   17'h200);
        directed("kclamp", 16'h8000, 16'h8000, 5'd20, 2'd1, 17'h00000, 17'h10000, 6, 4, 40'h10401, 17'h10000);
        directed("k0spec", 16'hFFFF, 16'hFFFF, 5'd0,  2'd3, 17'h1FFFE, 17'h1FFFE, 7, 4, 40'h10401, 17'h10000);

        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clr_stat_n", 64'(stat_n), 64'd0);
        chk("clr_stat_abs", 64'(stat_abs), 64'd0);
        chk("clr_stat_max", 64'(stat_max), 64'd0);

        // Backpressure: only two beats fit while the output is stalled.
        sb_en = 1'b1; acc_cnt = 0; del_cnt = 0;
        bus.out_ready = 1'b0; bus.cfg_k = 5'd0; bus.cfg_mode = 2'd0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (acc_cnt < 4);
            bus.a = 16'(acc_cnt + 1); bus.b = 16'(acc_cnt + 1);
            step();
        end
        chk("bp_accepted", 64'(acc_cnt), 64'd2);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_hold_sum", 64'(bus.sum_ext), 64'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && del_cnt < 4; i++) begin
            bus.in_valid = (acc_cnt < 4);
            bus.a = 16'(acc_cnt + 1); bus.b = 16'(acc_cnt + 1);
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_delivered", 64'(del_cnt), 64'd4);
        chk("bp_stat_n", 64'(stat_n), 64'd4);
        sb_en = 1'b0;

        // Clear coinciding with an erroring transfer keeps that transfer only.
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.a = 16'h01FF; bus.b = 16'h0001; bus.cfg_k = 5'd9; bus.cfg_mode = 2'd1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("clrx_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1; stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clrx_stat_n", 64'(stat_n), 64'd1);
        chk("clrx_stat_nerr", 64'(stat_nerr), 64'd1);
        chk("clrx_stat_abs", 64'(stat_abs), 64'h200);
        chk("clrx_stat_max", 64'(stat_max), 64'h200);

        // Random traffic with per-beat cfg changes against the model.
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        m_n = 64'd0; m_nerr = 64'd0; m_abs = 64'd0; m_max = 64'd0;
        sb_en = 1'b1; acc_cnt = 0; del_cnt = 0;
        for (int i = 0; i < 20000 && del_cnt < 1000; i++) begin
            bus.in_valid  = (acc_cnt < 1000) && ($urandom_range(0, 9) < 8);
            bus.a         = 16'($urandom);
            bus.b         = 16'($urandom);
            bus.cfg_k     = 5'($urandom_range(0, 31));
            bus.cfg_mode  = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        sb_en = 1'b0;
        chk("rnd_delivered", 64'(del_cnt), 64'd1000);
        chk("rnd_stat_n", 64'(stat_n), m_n);
        chk("rnd_stat_nerr", 64'(stat_nerr), m_nerr);
        chk("rnd_stat_abs", 64'(stat_abs), m_abs);
        chk("rnd_stat_max", 64'(stat_max), m_max);

        // Reset with the pipeline full and stalled.
        bus.out_ready = 1'b0; bus.in_valid = 1'b1;
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cfg_k = 5'd4; bus.cfg_mode = 2'd1;
        step(); step(); step();
        chk("mid_out_valid_pre", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_sum_apx", 64'(bus.sum_apx), 64'd0);
        chk("mid_sum_ext", 64'(bus.sum_ext), 64'd0);
        chk("mid_err_flag", 64'(bus.err_flag), 64'd0);
        chk("mid_stat_n", 64'(stat_n), 64'd0);
        chk("mid_stat_nerr", 64'(stat_nerr), 64'd0);
        chk("mid_stat_abs", 64'(stat_abs), 64'd0);
        chk("mid_stat_max", 64'(stat_max), 64'd0);
        chk("mid_in_ready_rst", 64'(bus.in_ready), 64'd0);
        rst = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("mid_in_ready_after", 64'(bus.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
